// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard: per-register in-flight write counters gate instruction issue.
// Latency: issue_ready is combinational; pending_mask and counters update one cycle after issue/writeback.
// Backpressure: issue_ready drops on RAW against a pending write, on counter saturation, on flush and in reset.
module reg_scoreboard #(
   parameter int REG_NUM = 32,
   parameter int ADDR_W  = 5,
   parameter int CNT_W   = 2,
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               issue_valid,
   output logic               issue_ready,
   input  logic               rs1_en,
   input  logic [ADDR_W-1:0]  rs1_addr,
   input  logic               rs2_en,
   input  logic [ADDR_W-1:0]  rs2_addr,
   input  logic               rd_we,
   input  logic [ADDR_W-1:0]  rd_addr,
   input  logic               wb_valid,
   input  logic [ADDR_W-1:0]  wb_addr,
   input  logic               flush,
   output logic [REG_NUM-1:0] pending_mask,
   output logic [STALL_W-1:0] stall_cnt,
   output logic               err_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0]   cnt [REG_NUM];
   logic               rs1_hz, rs2_hz, rd_hz, fire;
   logic [REG_NUM-1:0] inc_v, dec_v;

   // A source is still blocked if more writes are pending than the one retiring this cycle.
   always_comb begin
      rs1_hz = rs1_en && (rs1_addr != '0) &&
               (cnt[rs1_addr] > CNT_W'(wb_valid && (wb_addr == rs1_addr)));
      rs2_hz = rs2_en && (rs2_addr != '0) &&
               (cnt[rs2_addr] > CNT_W'(wb_valid && (wb_addr == rs2_addr)));
      rd_hz  = rd_we && (rd_addr != '0) && (cnt[rd_addr] == CNT_MAX);
      issue_ready = !rst && !flush && !rs1_hz && !rs2_hz && !rd_hz;
      fire = issue_valid && issue_ready && rd_we;
   end

   always_comb begin
      inc_v        = '0;
      dec_v        = '0;
      pending_mask = '0;
      for (int i = 1; i < REG_NUM; i++) begin
         inc_v[i]        = fire && (rd_addr == ADDR_W'(i));
         dec_v[i]        = wb_valid && (wb_addr == ADDR_W'(i)) && (cnt[i] != '0);
         pending_mask[i] = (cnt[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
         stall_cnt     <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (issue_valid && !issue_ready && (stall_cnt != {STALL_W{1'b1}}))
            stall_cnt <= stall_cnt + STALL_W'(1);
         if (flush) begin
            for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
         end else begin
            if (wb_valid && (wb_addr != '0) && (cnt[wb_addr] == '0))
               err_underflow <= 1'b1;
            cnt[0] <= '0;
            for (int i = 1; i < REG_NUM; i++) begin
               if (inc_v[i] && !dec_v[i])
                  cnt[i] <= cnt[i] + CNT_W'(1);
               else if (dec_v[i] && !inc_v[i])
                  cnt[i] <= cnt[i] - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, randomized traffic against a counting model,
// and a long stall run to reach counter saturation.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst, issue_valid, issue_ready;
   logic        rs1_en, rs2_en, rd_we, wb_valid, flush;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_addr;
   logic [31:0] pending_mask;
   logic [15:0] stall_cnt;
   logic        err_underflow;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_scoreboard #(.REG_NUM(32), .ADDR_W(5), .CNT_W(2), .STALL_W(16)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs2_en(rs2_en), .rs2_addr(rs2_addr),
      .rd_we(rd_we), .rd_addr(rd_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .flush(flush), .pending_mask(pending_mask), .stall_cnt(stall_cnt),
      .err_underflow(err_underflow)
   );

   typedef struct {
      logic r, v, e1; logic [4:0] a1; logic e2; logic [4:0] a2;
      logic w; logic [4:0] d; logic b; logic [4:0] ba; logic f;
      logic rdy; logic [31:0] mask; int stall; logic err;
   } vec_t;

   vec_t tbl[$];

   // Reference state: outstanding write count per register, stall count, error flag.
   int mcnt [32];
   int mstall;
   bit merr;

   task automatic add(input logic r, v, e1, input int a1, input logic e2, input int a2,
                      input logic w, input int d, input logic b, input int ba, input logic f,
                      input logic rdy, input logic [31:0] mask, input int stall, input logic err);
      vec_t t;
      t.r = r; t.v = v; t.e1 = e1; t.a1 = 5'(a1); t.e2 = e2; t.a2 = 5'(a2);
      t.w = w; t.d = 5'(d); t.b = b; t.ba = 5'(ba); t.f = f;
      t.rdy = rdy; t.mask = mask; t.stall = stall; t.err = err;
      tbl.push_back(t);
   endtask

   task automatic drive(input vec_t t);
      rst = t.r; issue_valid = t.v; rs1_en = t.e1; rs1_addr = t.a1; rs2_en = t.e2;
      rs2_addr = t.a2; rd_we = t.w; rd_addr = t.d; wb_valid = t.b; wb_addr = t.ba; flush = t.f;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int eff(input int r);
      int e;
      e = mcnt[r] - ((wb_valid && int'(wb_addr) == r) ? 1 : 0);
      return (e < 0) ? 0 : e;
   endfunction

   function automatic bit m_ready();
      if (rst || flush) return 0;
      if (rs1_en && rs1_addr != 0 && eff(int'(rs1_addr)) != 0) return 0;
      if (rs2_en && rs2_addr != 0 && eff(int'(rs2_addr)) != 0) return 0;
      if (rd_we && rd_addr != 0 && mcnt[rd_addr] == 3) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m = '0;
      for (int i = 1; i < 32; i++) m[i] = (mcnt[i] != 0);
      return m;
   endfunction

   task automatic m_step(input bit rdy);
      if (rst) begin
         foreach (mcnt[i]) mcnt[i] = 0;
         mstall = 0; merr = 0;
         return;
      end
      if (issue_valid && !rdy && mstall < 65535) mstall++;
      if (flush) begin
         foreach (mcnt[i]) mcnt[i] = 0;
         return;
      end
      if (wb_valid && wb_addr != 0) begin
         if (mcnt[wb_addr] == 0) merr = 1;
         else mcnt[wb_addr]--;
      end
      if (issue_valid && rdy && rd_we && rd_addr != 0) mcnt[rd_addr]++;
   endtask

   localparam logic [31:0] M2 = 32'h1 << 2, M3 = 32'h1 << 3, M4 = 32'h1 << 4, M5 = 32'h1 << 5;
   localparam logic [31:0] M7 = 32'h1 << 7, M9 = 32'h1 << 9, M12 = 32'h1 << 12;

   initial begin
      vec_t t;
      bit   er;
      // reset held, then reset-state and same-cycle RAW release
      add(1,1,0,0,0,0,0,0,0,0,0, 0,0,0,0);
      add(0,1,1,5,0,0,1,5,0,0,0, 1,0,0,0);
      add(0,1,1,5,0,0,0,0,0,0,0, 0,M5,0,0);
      add(0,1,1,5,0,0,0,0,0,0,0, 0,M5,1,0);
      add(0,1,1,5,0,0,0,0,1,5,0, 1,M5,2,0);
      add(0,0,0,0,0,0,0,0,0,0,0, 1,0,2,0);
      // saturate cnt[7]; overflow hazard ignores same-cycle writeback
      add(0,1,0,0,0,0,1,7,0,0,0, 1,0,2,0);
      add(0,1,0,0,0,0,1,7,0,0,0, 1,M7,2,0);
      add(0,1,0,0,0,0,1,7,0,0,0, 1,M7,2,0);
      add(0,1,0,0,0,0,1,7,0,0,0, 0,M7,2,0);
      add(0,1,0,0,0,0,1,7,1,7,0, 0,M7,3,0);
      add(0,1,1,7,0,0,0,0,1,7,0, 0,M7,4,0);
      add(0,1,0,0,0,0,1,7,0,0,0, 1,M7,5,0);
      add(0,1,0,0,0,0,1,7,1,7,0, 1,M7,5,0);
      add(0,1,0,0,0,0,1,7,0,0,0, 1,M7,5,0);
      add(0,1,0,0,0,0,1,7,0,0,0, 0,M7,5,0);
      add(0,0,0,0,0,0,0,0,1,7,0, 1,M7,6,0);
      add(0,0,0,0,0,0,0,0,1,7,0, 1,M7,6,0);
      add(0,0,0,0,0,0,0,0,1,7,0, 1,M7,6,0);
      // register 0 never tracked, never stalls, never errors
      add(0,1,1,0,0,0,1,0,1,0,0, 1,0,6,0);
      add(0,1,1,0,1,0,0,0,0,0,0, 1,0,6,0);
      // flush priority
      add(0,1,0,0,0,0,1,3,0,0,0, 1,0,6,0);
      add(0,1,0,0,0,0,1,9,0,0,0, 1,M3,6,0);
      add(0,1,0,0,0,0,1,4,1,3,1, 0,M3|M9,6,0);
      add(0,1,1,3,1,9,1,4,0,0,0, 1,0,7,0);
      add(0,0,0,0,0,0,0,0,1,4,0, 1,M4,7,0);
      // underflow is sticky
      add(0,0,0,0,0,0,0,0,1,12,0, 1,0,7,0);
      add(0,1,0,0,0,0,1,12,0,0,0, 1,0,7,1);
      add(0,0,0,0,0,0,0,0,1,12,0, 1,M12,7,1);
      add(0,0,0,0,0,0,0,0,0,0,0, 1,0,7,1);
      // reset overrides everything in its cycle
      add(1,1,0,0,0,0,1,2,1,20,1, 0,0,7,1);
      add(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0);
      // rs2 hazard, disabled rs1, ready independent of issue_valid
      add(0,1,0,0,0,0,1,2,0,0,0, 1,0,0,0);
      add(0,1,0,0,1,2,0,0,0,0,0, 0,M2,0,0);
      add(0,1,0,2,1,2,0,0,0,0,0, 0,M2,1,0);
      add(0,0,0,0,1,2,0,0,0,0,0, 0,M2,2,0);
      add(0,0,0,0,0,0,0,0,1,2,0, 1,M2,2,0);
      add(0,1,0,2,0,2,0,0,0,0,0, 1,0,2,0);

      t = tbl[0];
      drive(t);
      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[k]) begin
         drive(tbl[k]);
         @(negedge clk);
         chk($sformatf("row%0d.ready", k), 32'(issue_ready), 32'(tbl[k].rdy));
         chk($sformatf("row%0d.mask", k), pending_mask, tbl[k].mask);
         chk($sformatf("row%0d.stall", k), 32'(stall_cnt), 32'(tbl[k].stall));
         chk($sformatf("row%0d.err", k), 32'(err_underflow), 32'(tbl[k].err));
         @(posedge clk);
         #1;
      end

      // random traffic against the model, starting from reset
      t = tbl[0];
      drive(t);
      @(posedge clk);
      #1;
      m_step(1'b0);
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 255) == 0);
         flush       = ($urandom_range(0, 31) == 0);
         issue_valid = $urandom_range(0, 1);
         rs1_en      = $urandom_range(0, 1);
         rs2_en      = $urandom_range(0, 1);
         rd_we       = $urandom_range(0, 3) != 0;
         wb_valid    = $urandom_range(0, 2) == 0;
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         rd_addr     = 5'($urandom_range(0, 7));
         wb_addr     = 5'($urandom_range(0, 8));
         er = m_ready();
         @(negedge clk);
         chk($sformatf("rnd%0d.ready", n), 32'(issue_ready), 32'(er));
         chk($sformatf("rnd%0d.mask", n), pending_mask, m_mask());
         chk($sformatf("rnd%0d.stall", n), 32'(stall_cnt), 32'(mstall));
         chk($sformatf("rnd%0d.err", n), 32'(err_underflow), 32'(merr));
         @(posedge clk);
         m_step(er);
         #1;
      end

      // stall counter saturation
      t = tbl[0];
      drive(t);
      rst = 1'b0; flush = 1'b1; issue_valid = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_saturate", 32'(stall_cnt), 32'hFFFF);
      chk("flush_ready", 32'(issue_ready), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_hold", 32'(stall_cnt), 32'hFFFF);
      chk("flush_mask", pending_mask, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
